n64_ctrl_responder: RTL and testbench
=====================================

// Module: n64_ctrl_responder
// PURPOSE
//  Controller-side (responder) end of the N64 one-wire joybus link. Decodes console command
//  bytes on the open-drain data line and answers with an ID or button-state frame.
//  CPU access is through an APB3 slave on the MSS fabric APB bus, in the same slot as the
//  console-side interface. Used to emulate a pad and as a loopback target for con_int.
// PARAMETERS
//  CLK_PER_US   100  PCLK cycles per microsecond; all line timing derives from it
//  TURN_US      2    line-high gap between console stop bit and first response bit
//  IDLE_US      5    line-high time that aborts a partially received frame
//  ID_DEFAULT   24'h050002  reset value of the ID register
// PORTS
//  PCLK      in   1   fabric clock (FAB_CLK)
//  PRESERN   in   1   reset, synchronous, active-low
//  PSEL      in   1   APB select
//  PENABLE   in   1   APB enable
//  PWRITE    in   1   APB write
//  PADDR     in   32  APB address; only [3:2] decoded
//  PWDATA    in   32  APB write data
//  PRDATA    out  32  APB read data
//  PREADY    out  1   tied 1
//  PSLVERR   out  1   tied 0
//  data_in   in   1   raw line level (async)
//  data_oe   out  1   1 = pull line low; top level does data_line = data_oe ? 1'b0 : 1'bz
//  busy      out  1   frame in progress (rx or tx)
// BEHAVIOUR
//  Reset: data_oe=0, busy=0, BUTTONS=0, ID=ID_DEFAULT, ENABLE=0, counters=0, FSM=IDLE.
//   PRESERN low mid-frame releases the line on the next PCLK edge.
//  Registers:
//   - 0x0 BUTTONS rw: 32-bit poll response.
//   - 0x4 STATUS: read [7:0]=last cmd, [15:8]=resp_cnt (wraps 255->0),
//     [23:16]=err_cnt (saturates at 255), [24]=busy; write with PWDATA[31]=1 clears both counters.
//   - 0x8 ID rw: [23:0] only.
//   - 0xC CTRL rw: [0]=ENABLE.
//   Writes take effect on PSEL&PENABLE&PWRITE. PRDATA is combinational from the registers.
//  Line input: 2-FF synchronizer, then falling-edge detect. All timing is measured from the
//   synchronized edge. Let C = CLK_PER_US.
//  FSM states: IDLE, RX_SAMPLE, RX_WAIT, TURN, TX_LOW, TX_HIGH, TX_STOP, DRAIN.
//   - IDLE: wait for a falling edge while ENABLE=1 (edges are ignored while ENABLE=0),
//     then go to RX_SAMPLE with bit count = 0.
//   - RX_SAMPLE: sample the line 2C cycles after the edge. Bits shift in MSB first.
//     While count < 8: 1 -> bit 1, 0 -> bit 0; count++; go to RX_WAIT.
//     When count == 8: high -> stop bit accepted; low -> extra bits, go to DRAIN
//     (err_cnt++, no response).
//   - RX_WAIT: wait for the next falling edge. If the line stays high IDLE_US*C cycles:
//     abort to IDLE, err_cnt++.
//   - Stop accepted: latch last cmd.
//     0x00 or 0xFF -> response = ID, 24 bits.
//     0x01 -> response = BUTTONS, 32 bits.
//     Any other command -> IDLE, err_cnt++.
//     The response word is snapshotted at stop acceptance; APB writes during TX affect
//     only the next frame.
//   - TURN: wait for the synchronized line high plus TURN_US*C cycles, then TX.
//   - TX: bits go out MSB first, 4C cycles per bit.
//     Bit 0: data_oe=1 for 3C, then 0 for C. Bit 1: data_oe=1 for C, then 0 for 3C.
//   - TX_STOP: data_oe=1 for 2C, then release; resp_cnt++; go to IDLE.
//     The receiver ignores the line during TURN/TX.
//   - DRAIN: wait for IDLE_US*C high cycles, then IDLE.
//  busy=1 in every state except IDLE. Clearing ENABLE mid-frame has no effect until IDLE.
// TESTING
//  - ENABLE=1, ID=0x050002; console BFM sends 0x00 + stop -> after 2us gap, 24 bits
//    0x050002 + 2us-low stop on data_oe; resp_cnt=1.
//  - BUTTONS=0x8000_7F80; console sends 0x01 -> 32-bit frame 0x80007F80; STATUS[7:0]=0x01.
//  - BUTTONS written to 0x1 during a 0x01 response -> this frame still carries the old
//    value; next poll returns 0x1.
//  - Console sends 0x01 then holds high after bit 4 -> abort after 5us, err_cnt=1,
//    data_oe never asserted.
//  - Console sends 0x02 + extra address bits -> DRAIN, no response, err_cnt++.
//    ENABLE=0 + 0x01 -> no response, busy stays 0.
//  - PRESERN low during TX_LOW -> data_oe=0 next cycle, all registers at reset values.
//    255 responses then 1 more -> resp_cnt=0.

Source files
------------

// File: rtl/n64_ctrl_responder.sv
// N64 joybus controller-side responder: decodes console command bytes on the one-wire
// line and answers with the ID or button frame; configured through an APB3 slave.
`timescale 1ns/1ps
module n64_ctrl_responder #(
  parameter int          CLK_PER_US = 100,
  parameter int          TURN_US    = 2,
  parameter int          IDLE_US    = 5,
  parameter logic [23:0] ID_DEFAULT = 24'h050002
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        data_in,
  output logic        data_oe,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RX_SAMPLE, ST_RX_WAIT, ST_TURN, ST_TX_LOW, ST_TX_HIGH, ST_TX_STOP, ST_DRAIN
  } state_t;

  localparam logic [15:0] T_1U   = 16'(CLK_PER_US - 1);
  localparam logic [15:0] T_2U   = 16'(2 * CLK_PER_US - 1);
  localparam logic [15:0] T_3U   = 16'(3 * CLK_PER_US - 1);
  localparam logic [15:0] T_TURN = 16'(TURN_US * CLK_PER_US - 1);
  localparam logic [15:0] T_IDLE = 16'(IDLE_US * CLK_PER_US - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic        sync1_q, sync2_q, line_prev_q;
  state_t      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d, len_q, len_d;
  logic [7:0]  cmd_q, cmd_d, last_cmd_q, last_cmd_d;
  logic [31:0] shift_q, shift_d, buttons_q, buttons_d;
  logic [23:0] id_q, id_d;
  logic        enable_q, enable_d;
  logic [7:0]  resp_cnt_q, resp_cnt_d, err_cnt_q, err_cnt_d;
  logic        oe_q, oe_d, busy_q, busy_d;
  logic        line_s, fall, wr, clr, err_inc, resp_inc;
  logic [1:0]  addr;
  logic        unused_ok;

  assign line_s    = sync2_q;
  assign fall      = line_prev_q & ~sync2_q;
  assign addr      = PADDR[3:2];
  assign wr        = PSEL & PENABLE & PWRITE;
  assign clr       = wr && (addr == 2'd1) && PWDATA[31];
  assign unused_ok = &{1'b0, PADDR[31:4], PADDR[1:0]};

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign data_oe = oe_q;
  assign busy    = busy_q;

  always_comb begin
    case (addr)
      2'd0:    PRDATA = buttons_q;
      2'd1:    PRDATA = {7'd0, busy_q, err_cnt_q, resp_cnt_q, last_cmd_q};
      2'd2:    PRDATA = {8'd0, id_q};
      default: PRDATA = {31'd0, enable_q};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q + 16'd1;
    bit_cnt_d  = bit_cnt_q;
    len_d      = len_q;
    cmd_d      = cmd_q;
    last_cmd_d = last_cmd_q;
    shift_d    = shift_q;
    err_inc    = 1'b0;
    resp_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (enable_q && fall) begin
          state_d   = ST_RX_SAMPLE;
          bit_cnt_d = '0;
        end
      end
      ST_RX_SAMPLE: if (tmr_q == T_2U) begin
        tmr_d = '0;
        if (bit_cnt_q < 6'd8) begin
          cmd_d     = {cmd_q[6:0], line_s};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = ST_RX_WAIT;
        end else if (!line_s) begin
          err_inc = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          // Response word is frozen here so APB writes during TX only affect the next frame
          last_cmd_d = cmd_q;
          bit_cnt_d  = '0;
          if (cmd_q == 8'h00 || cmd_q == 8'hFF) begin
            shift_d = {id_q, 8'h00};
            len_d   = 6'd24;
            state_d = ST_TURN;
          end else if (cmd_q == 8'h01) begin
            shift_d = buttons_q;
            len_d   = 6'd32;
            state_d = ST_TURN;
          end else begin
            err_inc = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RX_WAIT: begin
        if (fall) begin
          state_d = ST_RX_SAMPLE;
          tmr_d   = '0;
        end else if (!line_s) begin
          tmr_d = '0;
        end else if (tmr_q == T_IDLE) begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_TURN: begin
        if (!line_s) begin
          tmr_d = '0;
        end else if (tmr_q == T_TURN) begin
          state_d = ST_TX_LOW;
          tmr_d   = '0;
        end
      end
      ST_TX_LOW: if (tmr_q == (shift_q[31] ? T_1U : T_3U)) begin
        state_d = ST_TX_HIGH;
        tmr_d   = '0;
      end
      ST_TX_HIGH: if (tmr_q == (shift_q[31] ? T_3U : T_1U)) begin
        tmr_d     = '0;
        shift_d   = {shift_q[30:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 6'd1;
        state_d   = (bit_cnt_q == len_q - 6'd1) ? ST_TX_STOP : ST_TX_LOW;
      end
      ST_TX_STOP: if (tmr_q == T_2U) begin
        state_d  = ST_IDLE;
        resp_inc = 1'b1;
      end
      default: begin
        if (!line_s) begin
          tmr_d = '0;
        end else if (tmr_q == T_IDLE) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    oe_d   = (state_d == ST_TX_LOW) || (state_d == ST_TX_STOP);
    busy_d = (state_d != ST_IDLE);

    buttons_d  = (wr && addr == 2'd0) ? PWDATA : buttons_q;
    id_d       = (wr && addr == 2'd2) ? PWDATA[23:0] : id_q;
    enable_d   = (wr && addr == 2'd3) ? PWDATA[0] : enable_q;
    resp_cnt_d = clr ? 8'd0 : resp_cnt_q + {7'd0, resp_inc};
    err_cnt_d  = clr ? 8'd0 : (err_inc ? sat_inc(err_cnt_q) : err_cnt_q);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      bit_cnt_q   <= '0;
      len_q       <= '0;
      cmd_q       <= '0;
      last_cmd_q  <= '0;
      shift_q     <= '0;
      buttons_q   <= '0;
      id_q        <= ID_DEFAULT;
      enable_q    <= 1'b0;
      resp_cnt_q  <= '0;
      err_cnt_q   <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= data_in;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_cnt_q   <= bit_cnt_d;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      last_cmd_q  <= last_cmd_d;
      shift_q     <= shift_d;
      buttons_q   <= buttons_d;
      id_q        <= id_d;
      enable_q    <= enable_d;
      resp_cnt_q  <= resp_cnt_d;
      err_cnt_q   <= err_cnt_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_n64_ctrl_responder.sv
// Directed bench for n64_ctrl_responder: a console BFM drives command frames and the
// response is decoded from data_oe pulse widths.
`timescale 1ns/1ps
module tb_n64_ctrl_responder;

  localparam int C = 2;

  logic        clk = 1'b0;
  logic        presern = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        con_drv = 1'b1;
  logic        data_in, data_oe, busy;

  int total = 0;
  int bad   = 0;
  int oe_cycles = 0;
  int busy_cycles = 0;

  assign data_in = data_oe ? 1'b0 : con_drv;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    oe_cycles   <= oe_cycles + (data_oe ? 1 : 0);
    busy_cycles <= busy_cycles + (busy ? 1 : 0);
  end

  n64_ctrl_responder #(.CLK_PER_US(C), .TURN_US(2), .IDLE_US(5), .ID_DEFAULT(24'h050002)) dut (
    .PCLK(clk), .PRESERN(presern), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .data_in(data_in), .data_oe(data_oe), .busy(busy)
  );

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    con_drv = 1'b0;
    repeat ((b ? 1 : 3) * C) @(negedge clk);
    con_drv = 1'b1;
    repeat ((b ? 3 : 1) * C - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_stop();
    @(negedge clk);
    con_drv = 1'b0;
    repeat (C) @(negedge clk);
    con_drv = 1'b1;
  endtask

  // Decode n response bits plus the stop pulse from data_oe low-pulse widths
  task automatic capture(input int n, output logic [31:0] data, output int stop_len,
                         output bit ok);
    int w, cnt;
    data = '0; stop_len = 0; ok = 1'b1;
    for (int i = 0; i <= n; i++) begin
      w = 0;
      while (data_oe !== 1'b1 && w < 300) begin @(negedge clk); w++; end
      if (w >= 300) begin ok = 1'b0; return; end
      cnt = 0;
      while (data_oe === 1'b1 && cnt < 100) begin @(negedge clk); cnt++; end
      if (i == n) stop_len = cnt;
      else begin
        if (cnt != C && cnt != 3 * C) ok = 1'b0;
        data = {data[30:0], (cnt == C)};
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    presern = 1'b0;
    repeat (4) @(negedge clk);
    presern = 1'b1;
    @(negedge clk);
    total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", data_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    apb_read(32'h0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_buttons got=%h want=0", r); end
    apb_read(32'h4, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_status got=%h want=0", r); end
    apb_read(32'h8, r);
    total++; if (r !== 32'h00050002) begin bad++; $display("FAIL reset_id got=%h want=00050002", r); end
    apb_read(32'hC, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", r); end
  endtask

  task automatic test_id_response();
    logic [31:0] d, r; int sl; bit ok;
    apb_write(32'hC, 32'h1);
    send_byte(8'h00); send_stop();
    capture(24, d, sl, ok);
    total++; if (!ok) begin bad++; $display("FAIL id_frame_format got=timeout/badwidth want=ok"); end
    total++; if (d !== 32'h00050002) begin bad++; $display("FAIL id_data got=%h want=00050002", d); end
    total++; if (sl != 2 * C) begin bad++; $display("FAIL id_stop_len got=%0d want=%0d", sl, 2 * C); end
    repeat (10) @(negedge clk);
    apb_read(32'h4, r);
    total++; if (r !== 32'h00000100) begin bad++; $display("FAIL id_status got=%h want=00000100", r); end
  endtask

  task automatic test_poll();
    logic [31:0] d, r; int sl; bit ok;
    apb_write(32'h0, 32'h80007F80);
    send_byte(8'h01); send_stop();
    capture(32, d, sl, ok);
    total++; if (!ok || d !== 32'h80007F80) begin bad++; $display("FAIL poll_data got=%h ok=%0d want=80007F80", d, ok); end
    total++; if (sl != 2 * C) begin bad++; $display("FAIL poll_stop_len got=%0d want=%0d", sl, 2 * C); end
    repeat (10) @(negedge clk);
    apb_read(32'h4, r);
    total++; if (r !== 32'h00000201) begin bad++; $display("FAIL poll_status got=%h want=00000201", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, r; int sl; bit ok;
    send_byte(8'h01); send_stop();
    fork
      capture(32, d, sl, ok);
      begin repeat (20) @(negedge clk); apb_write(32'h0, 32'h1); end
    join
    total++; if (!ok || d !== 32'h80007F80) begin bad++; $display("FAIL snapshot_old got=%h want=80007F80", d); end
    repeat (10) @(negedge clk);
    send_byte(8'h01); send_stop();
    capture(32, d, sl, ok);
    total++; if (!ok || d !== 32'h00000001) begin bad++; $display("FAIL snapshot_new got=%h want=00000001", d); end
    repeat (10) @(negedge clk);
    apb_read(32'h4, r);
    total++; if (r !== 32'h00000401) begin bad++; $display("FAIL b2b_status got=%h want=00000401", r); end
  endtask

  task automatic test_id_ff();
    logic [31:0] d, r; int sl; bit ok;
    apb_write(32'h8, 32'hFFABCDEF);
    apb_read(32'h8, r);
    total++; if (r !== 32'h00ABCDEF) begin bad++; $display("FAIL id_mask got=%h want=00ABCDEF", r); end
    send_byte(8'hFF); send_stop();
    capture(24, d, sl, ok);
    total++; if (!ok || d !== 32'h00ABCDEF) begin bad++; $display("FAIL idff_data got=%h want=00ABCDEF", d); end
    repeat (10) @(negedge clk);
    apb_read(32'h4, r);
    total++; if (r !== 32'h000005FF) begin bad++; $display("FAIL idff_status got=%h want=000005FF", r); end
  endtask

  task automatic test_abort();
    logic [31:0] r; int oe0;
    apb_write(32'h4, 32'h80000000);
    apb_read(32'h4, r);
    total++; if (r !== 32'h000000FF) begin bad++; $display("FAIL clear_status got=%h want=000000FF", r); end
    oe0 = oe_cycles;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    repeat (30) @(negedge clk);
    apb_read(32'h4, r);
    total++; if (r !== 32'h000100FF) begin bad++; $display("FAIL abort_status got=%h want=000100FF", r); end
    total++; if (oe_cycles != oe0) begin bad++; $display("FAIL abort_no_oe got=%0d want=%0d", oe_cycles, oe0); end
  endtask

  task automatic test_drain();
    logic [31:0] r; int oe0;
    oe0 = oe_cycles;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h03); send_stop();
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL drain_busy got=%b want=1", busy); end
    repeat (30) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_exit got=%b want=0", busy); end
    apb_read(32'h4, r);
    total++; if (r !== 32'h000200FF) begin bad++; $display("FAIL drain_status got=%h want=000200FF", r); end
    total++; if (oe_cycles != oe0) begin bad++; $display("FAIL drain_no_oe got=%0d want=%0d", oe_cycles, oe0); end
  endtask

  task automatic test_disabled();
    logic [31:0] r; int oe0, b0;
    apb_write(32'hC, 32'h0);
    oe0 = oe_cycles; b0 = busy_cycles;
    send_byte(8'h01); send_stop();
    repeat (30) @(negedge clk);
    total++; if (busy_cycles != b0) begin bad++; $display("FAIL dis_busy got=%0d want=%0d", busy_cycles, b0); end
    total++; if (oe_cycles != oe0) begin bad++; $display("FAIL dis_no_oe got=%0d want=%0d", oe_cycles, oe0); end
    apb_read(32'h4, r);
    total++; if (r !== 32'h000200FF) begin bad++; $display("FAIL dis_status got=%h want=000200FF", r); end
  endtask

  task automatic test_err_saturate();
    logic [31:0] r;
    apb_write(32'hC, 32'h1);
    for (int i = 0; i < 256; i++) begin
      send_bit(1'b0);
      repeat (18) @(negedge clk);
    end
    apb_read(32'h4, r);
    total++; if (r !== 32'h00FF00FF) begin bad++; $display("FAIL err_sat got=%h want=00FF00FF", r); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] r; int w;
    apb_write(32'h0, 32'h12345678);
    send_byte(8'h01); send_stop();
    w = 0;
    while (data_oe !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    total++; if (w >= 300) begin bad++; $display("FAIL rst_tx_start got=timeout want=data_oe"); end
    presern = 1'b0;
    @(negedge clk);
    total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL rst_tx_oe got=%b want=0", data_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_tx_busy got=%b want=0", busy); end
    apb_read(32'h0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_tx_buttons got=%h want=0", r); end
    apb_read(32'h4, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_tx_status got=%h want=0", r); end
    apb_read(32'h8, r);
    total++; if (r !== 32'h00050002) begin bad++; $display("FAIL rst_tx_id got=%h want=00050002", r); end
    apb_read(32'hC, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_tx_ctrl got=%h want=0", r); end
    presern = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_id_response();
    test_poll();
    test_back_to_back();
    test_id_ff();
    test_abort();
    test_drain();
    test_disabled();
    test_err_saturate();
    test_reset_mid_tx();
    total++; if (pready !== 1'b1 || pslverr !== 1'b0) begin bad++; $display("FAIL apb_ties got=%b%b want=10", pready, pslverr); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
